// File: rtl/hazard_scoreboard_unit.sv
// Operand bypass, long-latency scoreboard and stall/flush control for ID.
// Also keeps stall/flush perf counters and a sticky stall watchdog.
module hazard_scoreboard_unit #(
  parameter int XLEN     = 32,
  parameter int NFWD     = 3,
  parameter int MAX_PEND = 4,
  parameter int WDOG     = 255,
  parameter int CNTW     = 32
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic [1:0]         id_re,
  input  logic [4:0]         id_rd,
  input  logic               id_we,
  input  logic               id_long,
  input  logic [XLEN-1:0]    id_rD1,
  input  logic [XLEN-1:0]    id_rD2,
  input  logic [NFWD-1:0]    fwd_vld,
  input  logic [NFWD-1:0]    fwd_rdy,
  input  logic [5*NFWD-1:0]  fwd_rd,
  input  logic [XLEN*NFWD-1:0] fwd_data,
  input  logic               lr_vld,
  input  logic [4:0]         lr_rd,
  input  logic [XLEN-1:0]    lr_data,
  input  logic               ex_br_taken,
  output logic [XLEN-1:0]    new_rD1,
  output logic [XLEN-1:0]    new_rD2,
  output logic               stall,
  output logic               flush,
  output logic [CNTW-1:0]    stall_cnt,
  output logic [CNTW-1:0]    flush_cnt,
  output logic               hazard_err
);

  localparam int PW = $clog2(MAX_PEND + 1);
  localparam int WW = $clog2(WDOG + 1);
  localparam logic [PW-1:0] PMAX = PW'(MAX_PEND);
  localparam logic [WW-1:0] WMAX = WW'(WDOG);

  logic [31:0]     sb_q, sb_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [CNTW-1:0] scnt_q, scnt_d;
  logic [CNTW-1:0] fcnt_q, fcnt_d;
  logic            err_q, err_d;

  logic [4:0]      src [2];
  logic [XLEN-1:0] rfd [2];
  logic [XLEN-1:0] opnd [2];
  logic [1:0]      haz;
  logic            lr_ok, cap, fire, set;

  // Oldest stage first so a younger match overrides it.
  always_comb begin
    src[0] = id_rs1;
    src[1] = id_rs2;
    rfd[0] = id_rD1;
    rfd[1] = id_rD2;
    for (int s = 0; s < 2; s++) begin
      opnd[s] = rfd[s];
      haz[s]  = 1'b0;
      if (!cpu_rst && id_re[s] && src[s] != 5'd0) begin
        if (lr_vld && lr_rd == src[s]) begin
          opnd[s] = lr_data;
        end else begin
          for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_vld[i] && fwd_rd[i*5 +: 5] == src[s]) begin
              opnd[s] = fwd_data[i*XLEN +: XLEN];
              haz[s]  = !fwd_rdy[i];
            end
          end
          if (sb_q[src[s]]) haz[s] = 1'b1;
        end
      end
    end
  end

  assign new_rD1 = opnd[0];
  assign new_rD2 = opnd[1];

  // A legal return frees a slot in the same cycle.
  assign lr_ok = lr_vld && pend_q != '0 && sb_q[lr_rd];
  assign cap   = id_valid && id_we && id_long &&
                 pend_q == PMAX && !lr_ok;
  assign flush = !cpu_rst && ex_br_taken;
  assign stall = !cpu_rst && !ex_br_taken &&
                 ((id_valid && |haz) || cap);
  assign fire  = id_valid && !stall && !flush;
  assign set   = fire && id_we && id_long && id_rd != 5'd0;

  always_comb begin
    sb_d   = sb_q;
    pend_d = pend_q;
    wdog_d = '0;
    err_d  = err_q;
    scnt_d = scnt_q;
    fcnt_d = fcnt_q;
    if (lr_ok) sb_d[lr_rd] = 1'b0;
    if (set) sb_d[id_rd] = 1'b1;
    if (set && !lr_ok && pend_q != PMAX) begin
      pend_d = pend_q + 1'b1;
    end else if (lr_ok && !set) begin
      pend_d = pend_q - 1'b1;
    end
    if (lr_vld && !lr_ok) err_d = 1'b1;
    if (stall) begin
      wdog_d = (wdog_q == WMAX) ? wdog_q : wdog_q + 1'b1;
      if (wdog_d == WMAX) err_d = 1'b1;
      if (scnt_q != '1) scnt_d = scnt_q + 1'b1;
    end
    if (flush && fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      sb_q   <= '0;
      pend_q <= '0;
      wdog_q <= '0;
      scnt_q <= '0;
      fcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      sb_q   <= sb_d;
      pend_q <= pend_d;
      wdog_q <= wdog_d;
      scnt_q <= scnt_d;
      fcnt_q <= fcnt_d;
      err_q  <= err_d;
    end
  end

  assign stall_cnt  = scnt_q;
  assign flush_cnt  = fcnt_q;
  assign hazard_err = err_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit with hand-computed expectations.
// Inputs change 1 after the edge; outputs are sampled 1 later.
module tb_hazard_scoreboard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_re;
  logic        id_we, id_long;
  logic [31:0] id_rD1, id_rD2;
  logic [2:0]  fwd_vld, fwd_rdy;
  logic [14:0] fwd_rd;
  logic [95:0] fwd_data;
  logic        lr_vld;
  logic [4:0]  lr_rd;
  logic [31:0] lr_data;
  logic        br;
  logic [31:0] new_rD1, new_rD2;
  logic        stall, flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic        hazard_err;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit dut (
    .cpu_clk(clk), .cpu_rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re(id_re), .id_rd(id_rd), .id_we(id_we),
    .id_long(id_long), .id_rD1(id_rD1), .id_rD2(id_rD2),
    .fwd_vld(fwd_vld), .fwd_rdy(fwd_rdy), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .lr_vld(lr_vld), .lr_rd(lr_rd),
    .lr_data(lr_data), .ex_br_taken(br),
    .new_rD1(new_rD1), .new_rD2(new_rD2),
    .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .hazard_err(hazard_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_re = 0; id_we = 0; id_long = 0;
    id_rD1 = 32'hDEAD_0001; id_rD2 = 32'hDEAD_0002;
    fwd_vld = 0; fwd_rdy = 0; fwd_rd = 0; fwd_data = 0;
    lr_vld = 0; lr_rd = 0; lr_data = 0; br = 0;
  endtask

  task automatic set_fwd(input int i, input logic v,
                         input logic r, input logic [4:0] rd,
                         input logic [31:0] d);
    fwd_vld[i] = v;
    fwd_rdy[i] = r;
    fwd_rd[i*5 +: 5] = rd;
    fwd_data[i*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle();
    id_valid = 1; id_we = 1; id_long = 1; id_rd = rd;
  endtask

  initial begin
    idle();
    rst = 1;
    // Outputs during reset ignore a live hazard and branch.
    id_valid = 1; id_re = 2'b01; id_rs1 = 5'd6;
    set_fwd(0, 1, 0, 5'd6, 32'h1234); br = 1;
    settle();
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_rd1", new_rD1, 32'hDEAD_0001);
    step(); step();
    rst = 0; idle();
    settle();
    chk("rst_scnt", stall_cnt, 0);
    chk("rst_fcnt", flush_cnt, 0);
    chk("rst_err", hazard_err, 0);

    // 1) youngest stage wins; oldest-only match; x0 not matched
    idle(); id_valid = 1; id_re = 2'b11;
    id_rs1 = 5'd5; id_rs2 = 5'd9;
    set_fwd(0, 1, 1, 5'd5, 32'h11);
    set_fwd(1, 1, 1, 5'd5, 32'h22);
    set_fwd(2, 1, 1, 5'd9, 32'h33);
    settle();
    chk("t1_rd1", new_rD1, 32'h11);
    chk("t1_rd2_old", new_rD2, 32'h33);
    chk("t1_stall", stall, 0);
    id_rs2 = 5'd0; set_fwd(2, 1, 1, 5'd0, 32'h44);
    settle();
    chk("t1_x0", new_rD2, 32'hDEAD_0002);
    step();

    // 2) load-use stall then MEM data
    idle(); id_valid = 1; id_re = 2'b01; id_rs1 = 5'd6;
    set_fwd(0, 1, 0, 5'd6, 32'h0);
    settle();
    chk("t2_stall", stall, 1);
    step();
    set_fwd(0, 0, 0, 5'd0, 32'h0);
    set_fwd(1, 1, 1, 5'd6, 32'hCAFE);
    settle();
    chk("t2_rd1", new_rD1, 32'hCAFE);
    chk("t2_nostall", stall, 0);
    chk("t2_scnt", stall_cnt, 1);
    step();

    // 3) long op to x7, stall until return
    issue_long(5'd7);
    settle();
    chk("t3_fire", stall, 0);
    step();
    idle(); id_valid = 1; id_re = 2'b01; id_rs1 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_hold", stall, 1);
      step();
    end
    lr_vld = 1; lr_rd = 5'd7; lr_data = 32'h99;
    settle();
    chk("t3_lr_rd1", new_rD1, 32'h99);
    chk("t3_lr_stall", stall, 0);
    step();
    lr_vld = 0;
    settle();
    chk("t3_sb_clr", stall, 0);
    chk("t3_rf", new_rD1, 32'hDEAD_0001);
    chk("t3_scnt", stall_cnt, 4);

    // 4) capacity stall and same-register set/clear
    for (int k = 1; k <= 4; k++) begin
      issue_long(5'(k));
      settle();
      chk("t4_fill", stall, 0);
      step();
    end
    issue_long(5'd3);
    settle();
    chk("t4_cap", stall, 1);
    step();
    lr_vld = 1; lr_rd = 5'd3;
    settle();
    chk("t4_cap_lift", stall, 0);
    step();
    issue_long(5'd8);
    settle();
    chk("t4_still_full", stall, 1);
    idle(); id_valid = 1; id_re = 2'b01; id_rs1 = 5'd3;
    settle();
    chk("t4_sb3", stall, 1);
    idle();
    lr_vld = 1;
    for (int k = 1; k <= 4; k++) begin
      lr_rd = 5'(k);
      step();
    end
    idle(); id_valid = 1; id_re = 2'b11;
    id_rs1 = 5'd3; id_rs2 = 5'd1;
    settle();
    chk("t4_drained", stall, 0);
    chk("t4_noerr", hazard_err, 0);

    // 5) flush overrides stall, no scoreboard set
    idle(); id_valid = 1; id_we = 1; id_long = 1; id_rd = 5'd10;
    id_re = 2'b01; id_rs1 = 5'd6;
    set_fwd(0, 1, 0, 5'd6, 32'h0); br = 1;
    settle();
    chk("t5_flush", flush, 1);
    chk("t5_stall", stall, 0);
    step();
    idle(); id_valid = 1; id_re = 2'b01; id_rs1 = 5'd10;
    settle();
    chk("t5_nosb", stall, 0);
    chk("t5_fcnt", flush_cnt, 1);
    chk("t5_scnt", stall_cnt, 5);

    // 6) stray return sets sticky error; reset clears
    idle(); lr_vld = 1; lr_rd = 5'd12;
    step();
    idle();
    chk("t6_stray", hazard_err, 1);
    step();
    chk("t6_sticky", hazard_err, 1);
    rst = 1;
    step();
    rst = 0;
    settle();
    chk("t6_rst_err", hazard_err, 0);
    chk("t6_rst_scnt", stall_cnt, 0);
    chk("t6_rst_fcnt", flush_cnt, 0);

    // watchdog: 254 stall cycles clean, 255th trips
    idle(); id_valid = 1; id_re = 2'b01; id_rs1 = 5'd6;
    set_fwd(0, 1, 0, 5'd6, 32'h0);
    for (int k = 0; k < 254; k++) step();
    chk("t6_wd254", hazard_err, 0);
    step();
    chk("t6_wd255", hazard_err, 1);
    chk("t6_wd_scnt", stall_cnt, 255);

    // reset with pending op leaves no stale stall
    rst = 1; step(); rst = 0;
    issue_long(5'd7);
    step();
    rst = 1; idle(); step(); rst = 0;
    id_valid = 1; id_re = 2'b01; id_rs1 = 5'd7;
    settle();
    chk("t6_post_rst", stall, 0);
    chk("t6_post_err", hazard_err, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
